// File: rtl/scope_capture_ctrl.sv
// Triggered frame capture sequencer for the ADC sample FIFO write side.
// Optional forced auto-trigger in WAIT_TRIG: define SCOPE_AUTO_TRIG_EN.
module scope_capture_ctrl #(
  parameter int DEPTH = 640,
  parameter int CNT_W = 10
`ifdef SCOPE_AUTO_TRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 1048576
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic [7:0] trig_level,
  input  logic       trig_falling,
  input  logic       run,
  input  logic       arm,
  input  logic       abort,
  input  logic       wrempty,
  input  logic       wrfull,
  output logic       wrreq,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [2:0] state
`ifdef SCOPE_AUTO_TRIG_EN
  ,
  output logic       auto_fired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_EMPTY = 3'd1,
    S_WAIT_TRIG  = 3'd2,
    S_CAPTURE    = 3'd3,
    S_DONE       = 3'd4
  } st_e;

  st_e              st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       prev_q;
  logic             pok_q;
  logic             ovr_q;

  logic rise;
  logic fall;
  logic hit;
  logic forced;
  logic in_trig;
  logic in_cap;

  assign in_trig = (st_q == S_WAIT_TRIG);
  assign in_cap  = (st_q == S_CAPTURE);

  assign rise = sample_valid & pok_q
              & (prev_q < trig_level)
              & (sample >= trig_level);
  assign fall = sample_valid & pok_q
              & (prev_q > trig_level)
              & (sample <= trig_level);

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);

  logic [TW-1:0] tmo_q;
  logic          af_q;

  // Saturates one past the last wait cycle; any valid sample then fires.
  assign forced     = sample_valid & (tmo_q == TW'(AUTO_TIMEOUT));
  assign auto_fired = af_q;
`else
  assign forced = 1'b0;
`endif

  assign hit = (trig_falling ? fall : rise) | forced;

  assign wrreq = ~abort & sample_valid & ~wrfull
               & (in_cap | (in_trig & hit));

  assign wr_data = sample;
  assign busy    = (st_q != S_IDLE);
  assign done    = (st_q == S_DONE);
  assign overrun = ovr_q;
  assign state   = st_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      prev_q <= '0;
      pok_q  <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
      tmo_q  <= '0;
      af_q   <= 1'b0;
`endif
    end else if (abort) begin
      st_q <= S_IDLE;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (run | arm) begin
            st_q  <= S_WAIT_EMPTY;
            ovr_q <= 1'b0;
          end
        end
        S_WAIT_EMPTY: begin
          if (wrempty) begin
            st_q  <= S_WAIT_TRIG;
            cnt_q <= '0;
            pok_q <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
            tmo_q <= '0;
            af_q  <= 1'b0;
`endif
          end
        end
        S_WAIT_TRIG: begin
          if (sample_valid) begin
            prev_q <= sample;
            pok_q  <= 1'b1;
          end
`ifdef SCOPE_AUTO_TRIG_EN
          if (tmo_q != TW'(AUTO_TIMEOUT))
            tmo_q <= tmo_q + TW'(1);
          if (forced)
            af_q <= 1'b1;
`endif
          // The triggering sample is frame sample 0.
          if (hit) begin
            st_q  <= (DEPTH == 1) ? S_DONE : S_CAPTURE;
            cnt_q <= CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            prev_q <= sample;
            pok_q  <= 1'b1;
          end
          if (wrfull) begin
            st_q  <= S_DONE;
            ovr_q <= 1'b1;
          end else if (sample_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DEPTH - 1))
              st_q <= S_DONE;
          end
        end
        S_DONE: begin
          st_q <= run ? S_WAIT_EMPTY : S_IDLE;
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Randomized and directed bench for scope_capture_ctrl against a
// frame-level reference model (writes counted per frame, scoreboarded).
module tb_scope_capture_ctrl;

  localparam int DEPTH = 640;
`ifdef SCOPE_AUTO_TRIG_EN
  localparam int AUTO = 16;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample;
  logic       sample_valid;
  logic [7:0] trig_level;
  logic       trig_falling;
  logic       run;
  logic       arm;
  logic       abort;
  logic       wrempty;
  logic       wrfull;
  logic       wrreq;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       overrun;
  logic [2:0] state;
`ifdef SCOPE_AUTO_TRIG_EN
  logic       auto_fired;
`endif

  always #5 clk = ~clk;

  scope_capture_ctrl #(
    .DEPTH(DEPTH),
    .CNT_W(10)
`ifdef SCOPE_AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT(AUTO)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample(sample),
    .sample_valid(sample_valid),
    .trig_level(trig_level),
    .trig_falling(trig_falling),
    .run(run),
    .arm(arm),
    .abort(abort),
    .wrempty(wrempty),
    .wrfull(wrfull),
    .wrreq(wrreq),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .overrun(overrun),
    .state(state)
`ifdef SCOPE_AUTO_TRIG_EN
    ,
    .auto_fired(auto_fired)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: phase, writes in frame, last valid sample
  int m_st = 0;
  int m_wcnt = 0;
  int m_prev = 0;
  int m_wt = 0;
  bit m_pok = 0;
  bit m_ovr = 0;
  bit m_af = 0;

  // stimulus control
  int ramp = 0;
  int ramp_dir = 1;
  int vmode = 0;
  bit vtog = 0;
  bit rnd_data = 0;

  logic [7:0] fq[$];
  int exp_len = -1;
  int exp_first = -1;

  task automatic set_sample();
    bit v;
    case (vmode)
      0: v = 1'b1;
      1: begin vtog = ~vtog; v = vtog; end
      default: v = ($urandom % 4) != 0;
    endcase
    sample_valid = v;
    if (rnd_data) sample = 8'($urandom % 256);
    else sample = 8'(ramp);
    if (v && !rnd_data) ramp = (ramp + ramp_dir) & 255;
  endtask

  task automatic frame_check();
    int bad;
    chk("frame_len", fq.size(), exp_len);
    if (exp_first >= 0) begin
      chk("frame_first", (fq.size() > 0) ? int'(fq[0]) : -1, exp_first);
      bad = 0;
      foreach (fq[i])
        if (int'(fq[i]) != ((exp_first + i * ramp_dir) & 255)) bad++;
      chk("frame_ramp", bad, 0);
    end
  endtask

  task automatic cyc();
    bit v;
    bit hit;
    bit forced;
    bit e_wr;
    int s;
    int lv;
    set_sample();
    #1;
    v = sample_valid;
    s = int'(sample);
    lv = int'(trig_level);
    hit = v && m_pok && (trig_falling ? (m_prev > lv && s <= lv)
                                      : (m_prev < lv && s >= lv));
    forced = 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
    forced = v && (m_st == 2) && (m_wt >= AUTO);
    hit = hit | forced;
`endif
    e_wr = !abort && v && !wrfull && (m_st == 3 || (m_st == 2 && hit));
    chk("wrreq", wrreq, e_wr);
    chk("state", state, m_st);
    chk("busy", busy, m_st != 0);
    chk("done", done, m_st == 4);
    chk("overrun", overrun, m_ovr);
    chk("wr_data", wr_data, sample);
`ifdef SCOPE_AUTO_TRIG_EN
    chk("auto_fired", auto_fired, m_af);
`endif
    if (wrreq) fq.push_back(wr_data);
    if (m_st == 4 && exp_len >= 0) frame_check();
    if (abort) m_st = 0;
    else begin
      case (m_st)
        0: if (run || arm) begin m_st = 1; m_ovr = 0; end
        1: if (wrempty) begin
             m_st = 2; m_pok = 0; m_wt = 0; m_af = 0;
             fq.delete();
           end
        2: begin
             if (hit) begin
               m_st = 3; m_wcnt = 1;
               if (forced) m_af = 1;
             end
             m_wt++;
             if (v) begin m_prev = s; m_pok = 1; end
           end
        3: begin
             if (wrfull) begin m_st = 4; m_ovr = 1; end
             else if (e_wr) begin
               m_wcnt++;
               if (m_wcnt == DEPTH) m_st = 4;
             end
             if (v) begin m_prev = s; m_pok = 1; end
           end
        default: m_st = run ? 1 : 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_wrreq", wrreq, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    m_st = 0; m_pok = 0; m_ovr = 0; m_af = 0; m_wt = 0; m_wcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic go(input int n);
    repeat (n) cyc();
  endtask

  task automatic until_st(input int target, input int bound,
                          input string tag);
    int k = 0;
    while (m_st != target && k < bound) begin cyc(); k++; end
    chk(tag, state, target);
  endtask

  task automatic until_done(input int bound);
    until_st(4, bound, "to_done");
    cyc();
  endtask

  task automatic until_cnt(input int n, input int bound);
    int k = 0;
    while (!(m_st == 3 && m_wcnt == n) && k < bound) begin cyc(); k++; end
    chk("to_count", state, 3);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sample = '0; sample_valid = 1'b0;
    trig_level = 8'd128; trig_falling = 1'b0;
    run = 1'b0; arm = 1'b0; abort = 1'b0;
    wrempty = 1'b1; wrfull = 1'b0;
    @(negedge clk);
    do_reset();

    // reset mid-capture, then quiet until armed
    ramp = 120; ramp_dir = 1; vmode = 0;
    pulse_arm();
    until_cnt(100, 400);
    do_reset();
    go(20);
    chk("idle_after_rst", state, 0);

    // rising trigger on an incrementing ramp
    ramp = 120; exp_len = DEPTH; exp_first = 128;
    pulse_arm();
    until_done(2000);
    go(5);
    chk("idle_after_frame", state, 0);

    // falling trigger, valid every other cycle
    trig_level = 8'd64; trig_falling = 1'b1;
    ramp = 70; ramp_dir = -1; vmode = 1; exp_first = 64;
    pulse_arm();
    until_done(4000);
    go(4);

    // continuous run: hold while FIFO not empty, then re-trigger
    trig_level = 8'd128; trig_falling = 1'b0;
    ramp = 120; ramp_dir = 1; vmode = 0; exp_first = 128;
    run = 1'b1;
    until_done(2000);
    wrempty = 1'b0;
    go(50);
    chk("hold_wait_empty", state, 1);
    wrempty = 1'b1;
`ifdef SCOPE_AUTO_TRIG_EN
    exp_first = -1;
`endif
    until_st(2, 10, "to_wait_trig");
    until_cnt(10, 400);
    run = 1'b0;
    until_done(2000);
    go(3);
    chk("idle_after_run", state, 0);

    // FIFO full mid-frame ends it early with sticky overrun
    ramp = 120; exp_len = 300; exp_first = 128;
    pulse_arm();
    until_cnt(300, 1000);
    wrfull = 1'b1;
    cyc();
    wrfull = 1'b0;
    until_done(5);
    go(10);
    chk("overrun_sticky", overrun, 1);
    pulse_arm();
    chk("overrun_clr", overrun, 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_wait_empty", state, 0);

    // abort mid-capture
    exp_len = -1; exp_first = -1; ramp = 120;
    pulse_arm();
    until_cnt(50, 400);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_capture", state, 0);

    // constant sample below level: only the auto trigger can fire
    ramp = 10; ramp_dir = 0; trig_level = 8'd128;
`ifdef SCOPE_AUTO_TRIG_EN
    exp_len = DEPTH; exp_first = 10;
    pulse_arm();
    until_done(2000);
    chk("auto_fired_end", auto_fired, 1);
`else
    pulse_arm();
    go(200);
    chk("no_auto_trig", state, 2);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
`endif

    // randomized traffic
    exp_len = -1; exp_first = -1;
    rnd_data = 1'b1; vmode = 2;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom % 200 == 0) run = ~run;
      arm = ($urandom % 50) == 0;
      abort = ($urandom % 300) == 0;
      wrfull = ($urandom % 400) == 0;
      wrempty = ($urandom % 3) != 0;
      if ($urandom % 100 == 0) trig_level = 8'($urandom % 256);
      if ($urandom % 300 == 0) trig_falling = ~trig_falling;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
